// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 2-bit 4:1 picker: steps the select through channels 0..3,
// samples the picker output once per channel and publishes an 8-bit frame.
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  output logic [1:0] sel_o,
  input  logic [1:0] pick_i,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_o,
  output logic       changed
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_shadow;
  logic [7:0]       r_frame;
  logic             r_changed;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_state_nx;
  logic [1:0]       w_sel_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [5:0]       w_shadow_nx;
  logic [7:0]       w_frame_nx;
  logic             w_changed_nx;
  logic [7:0]       w_new_frame;
  logic             w_last;

  assign w_new_frame = {pick_i, r_shadow};
  assign w_last      = (r_cnt == CNT_LAST);

  // Next-state logic: stop overrides everything and discards the partial shadow.
  always_comb begin
    w_state_nx   = r_state;
    w_sel_nx     = r_sel;
    w_cnt_nx     = r_cnt;
    w_shadow_nx  = r_shadow;
    w_frame_nx   = r_frame;
    w_changed_nx = r_changed;
    if (stop) begin
      w_state_nx  = ST_IDLE;
      w_sel_nx    = 2'd0;
      w_cnt_nx    = CNT_ZERO;
      w_shadow_nx = 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_sel_nx = 2'd0;
          w_cnt_nx = CNT_ZERO;
          if (start) begin
            w_state_nx  = ST_SCAN;
            w_shadow_nx = 6'd0;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (w_last) begin
            w_cnt_nx = CNT_ZERO;
            case (r_sel)
              2'd0: w_shadow_nx[1:0] = pick_i;
              2'd1: w_shadow_nx[3:2] = pick_i;
              2'd2: w_shadow_nx[5:4] = pick_i;
              default: w_shadow_nx = r_shadow;
            endcase
            // Channel 3 closes the frame; the select wraps to 0 only through DONE.
            if (r_sel == 2'd3) begin
              w_state_nx   = ST_DONE;
              w_frame_nx   = w_new_frame;
              w_changed_nx = (w_new_frame != r_frame);
            end else begin
              w_sel_nx = r_sel + 2'd1;
            end
          end else begin
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end
        ST_DONE: begin
          w_sel_nx    = 2'd0;
          w_cnt_nx    = CNT_ZERO;
          w_shadow_nx = 6'd0;
          if (mode) begin
            w_state_nx = ST_SCAN;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
        default: begin
          w_state_nx  = ST_IDLE;
          w_sel_nx    = 2'd0;
          w_cnt_nx    = CNT_ZERO;
          w_shadow_nx = 6'd0;
        end
      endcase
    end
  end

  // State and output registers; busy/done are decoded from the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sel     <= 2'd0;
      r_cnt     <= CNT_ZERO;
      r_shadow  <= 6'd0;
      r_frame   <= 8'h00;
      r_changed <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_sel     <= w_sel_nx;
      r_cnt     <= w_cnt_nx;
      r_shadow  <= w_shadow_nx;
      r_frame   <= w_frame_nx;
      r_changed <= w_changed_nx;
      r_busy    <= (w_state_nx != ST_IDLE);
      r_done    <= (w_state_nx == ST_DONE);
    end
  end

  assign sel_o   = r_sel;
  assign busy    = r_busy;
  assign done    = r_done;
  assign frame_o = r_frame;
  assign changed = r_changed;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a DWELL=4 instance and a DWELL=1 instance,
// each driving a behavioural 4:1 picker built from the x[] channel table.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, stop4, mode4, busy4, done4, changed4;
  logic       start1, stop1, mode1, busy1, done1, changed1;
  logic [1:0] sel4, pick4, sel1, pick1;
  logic [7:0] frame4, frame1;
  logic [1:0] x [4];

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  assign pick4 = x[sel4];
  assign pick1 = x[sel1];

  mux_scan_ctrl #(.DWELL(4), .CNT_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop(stop4), .mode(mode4),
    .sel_o(sel4), .pick_i(pick4), .busy(busy4), .done(done4),
    .frame_o(frame4), .changed(changed4)
  );

  mux_scan_ctrl #(.DWELL(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .mode(mode1),
    .sel_o(sel1), .pick_i(pick1), .busy(busy1), .done(done1),
    .frame_o(frame1), .changed(changed1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; stop4 = 1'b0; mode4 = 1'b0;
    start1 = 1'b0; stop1 = 1'b0; mode1 = 1'b0;
    x[0] = 2'd1; x[1] = 2'd2; x[2] = 2'd3; x[3] = 2'd0;

    // 1. reset and idle
    tick();
    tick();
    chk("rst_sel", 8'(sel4), 8'h00);
    chk("rst_busy", 8'(busy4), 8'h00);
    chk("rst_done", 8'(done4), 8'h00);
    chk("rst_frame", frame4, 8'h00);
    chk("rst_changed", 8'(changed4), 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_sel", 8'(sel4), 8'h00);
      chk("idle_busy", 8'(busy4), 8'h00);
      chk("idle_done", 8'(done4), 8'h00);
      chk("idle_frame", frame4, 8'h00);
    end

    // 2. one-shot scan
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk("os_sel", 8'(sel4), 8'((c - 1) / 4));
      chk("os_busy", 8'(busy4), 8'h01);
      chk("os_done", 8'(done4), 8'h00);
      tick();
    end
    chk("os_done17", 8'(done4), 8'h01);
    chk("os_frame", frame4, 8'h39);
    chk("os_changed", 8'(changed4), 8'h01);
    chk("os_busy17", 8'(busy4), 8'h01);
    tick();
    chk("os_done18", 8'(done4), 8'h00);
    chk("os_busy18", 8'(busy4), 8'h00);
    chk("os_sel18", 8'(sel4), 8'h00);

    // 3. unchanged rescan with ignored start pulses
    n_done = 0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (done4) n_done++;
      if (c == 17) begin
        chk("rs_done17", 8'(done4), 8'h01);
        chk("rs_frame", frame4, 8'h39);
        chk("rs_changed", 8'(changed4), 8'h00);
      end
      if (c == 18) chk("rs_busy18", 8'(busy4), 8'h00);
      if (c == 5 || c == 17) start4 = 1'b1;
      tick();
      start4 = 1'b0;
    end
    chk("rs_done_count", 8'(n_done), 8'h01);

    // 4. continuous mode
    mode4 = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 51; c++) begin
      if (c == 20) x[2] = 2'd0;
      if (c == 51) mode4 = 1'b0;
      chk("ct_done", 8'(done4), 8'((c == 17) || (c == 34) || (c == 51)));
      if (c == 17) begin
        chk("ct_frame1", frame4, 8'h39);
        chk("ct_changed1", 8'(changed4), 8'h00);
      end
      if (c == 18) begin
        chk("ct_sel18", 8'(sel4), 8'h00);
        chk("ct_busy18", 8'(busy4), 8'h01);
      end
      if (c == 34) begin
        chk("ct_frame2", frame4, 8'h09);
        chk("ct_changed2", 8'(changed4), 8'h01);
      end
      if (c == 51) begin
        chk("ct_frame3", frame4, 8'h09);
        chk("ct_changed3", 8'(changed4), 8'h00);
      end
      tick();
    end
    chk("ct_busy52", 8'(busy4), 8'h00);

    // 5. abort, then start+stop together in idle
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) begin
        chk("ab_sel6", 8'(sel4), 8'h01);
        stop4 = 1'b1;
      end
      tick();
      stop4 = 1'b0;
    end
    chk("ab_sel7", 8'(sel4), 8'h00);
    chk("ab_busy7", 8'(busy4), 8'h00);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done4) n_done++;
      chk("ab_frame", frame4, 8'h09);
      tick();
    end
    chk("ab_no_done", 8'(n_done), 8'h00);
    start4 = 1'b1;
    stop4 = 1'b1;
    tick();
    start4 = 1'b0;
    stop4 = 1'b0;
    chk("ss_busy", 8'(busy4), 8'h00);
    tick();
    chk("ss_busy2", 8'(busy4), 8'h00);
    chk("ss_done2", 8'(done4), 8'h00);

    // 6. DWELL=1 scan, reset mid-scan, then a clean restart
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("d1_sel", 8'(sel1), 8'(c - 1));
      chk("d1_busy", 8'(busy1), 8'h01);
      chk("d1_done", 8'(done1), 8'h00);
      tick();
    end
    chk("d1_done5", 8'(done1), 8'h01);
    chk("d1_frame", frame1, 8'h09);
    chk("d1_changed", 8'(changed1), 8'h01);
    tick();
    chk("d1_done6", 8'(done1), 8'h00);
    chk("d1_busy6", 8'(busy1), 8'h00);

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    chk("mr_sel3", 8'(sel1), 8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_sel", 8'(sel1), 8'h00);
    chk("mr_busy", 8'(busy1), 8'h00);
    chk("mr_done", 8'(done1), 8'h00);
    chk("mr_frame", frame1, 8'h00);
    chk("mr_changed", 8'(changed1), 8'h00);
    chk("mr_frame4", frame4, 8'h00);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    chk("rr_done5", 8'(done1), 8'h01);
    chk("rr_frame", frame1, 8'h09);
    chk("rr_changed", 8'(changed1), 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
